acia_bridge: RTL and testbench

- Bus-master front end for the on-chip ACIA register interface; it takes the place of the CPU as the initiator of register accesses.
- Initialises the ACIA, then polls its status register continuously.
- Moves received bytes out to a valid/ready stream and accepts transmit bytes from a valid/ready stream.
- Lets fabric logic (test pattern generators, loopback monitors, bootloaders) use the serial port without the 6502.

---
 rtl/acia_bridge.sv | 163 ++++++++++++++++
 tb/tb_acia_bridge.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acia_bridge.sv
// acia_bridge: bus master that stands in for the CPU on the ACIA register port.
// It initialises the ACIA, polls the status register, and moves bytes between
// the ACIA data register and a pair of valid/ready byte streams.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_INIT_RST | write 0x03 to control (ACIA master reset)
// S_INIT_CFG | write CTRL_WORD to control
// S_POLL     | read status register
// S_STAT     | status on i_acia_dout; choose RX read, TX write or idle
// S_RXRD     | read data register (clears ACIA rx-full)
// S_RXCAP    | capture read data into the one-entry rx buffer
// S_TXWR     | write tx byte to data register while i_tx_valid is high
// S_GAP      | idle POLL_GAP cycles before the next status read
module acia_bridge #(
  parameter logic [7:0]  CTRL_WORD = 8'h15,
  parameter int unsigned POLL_GAP  = 0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       o_acia_cs,
  output logic       o_acia_we,
  output logic       o_acia_rs,
  output logic [7:0] o_acia_din,
  input  logic [7:0] i_acia_dout,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_rx_err,
  input  logic       i_err_clr
);

  typedef enum logic [2:0] {
    S_INIT_RST,
    S_INIT_CFG,
    S_POLL,
    S_STAT,
    S_RXRD,
    S_RXCAP,
    S_TXWR,
    S_GAP
  } state_t;

  // GAP is entered with the counter preloaded so it lasts exactly POLL_GAP cycles.
  localparam bit         GAP_EN   = (POLL_GAP > 0);
  localparam logic [7:0] GAP_LOAD = GAP_EN ? 8'(POLL_GAP - 1) : 8'd0;

  state_t     r_state;
  logic [7:0] r_gap_cnt;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_rx_err;

  wire        w_rx_full  = i_acia_dout[0];
  wire        w_tx_empty = i_acia_dout[1];
  wire        w_stat_err = i_acia_dout[4] | i_acia_dout[5];

  // Sequencer, rx buffer and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_INIT_RST;
      r_gap_cnt  <= 8'd0;
      r_rx_data  <= 8'd0;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      if (r_rx_valid && i_rx_ready) begin
        r_rx_valid <= 1'b0;
      end

      // A fresh error report outranks a simultaneous clear request.
      if (r_state == S_STAT && w_stat_err) begin
        r_rx_err <= 1'b1;
      end else if (i_err_clr) begin
        r_rx_err <= 1'b0;
      end

      case (r_state)
        S_INIT_RST: r_state <= S_INIT_CFG;
        S_INIT_CFG: r_state <= S_POLL;
        S_POLL:     r_state <= S_STAT;
        S_STAT: begin
          // Registered r_rx_valid is used on purpose: a pop in this cycle
          // only makes the next poll eligible for a data read.
          if (w_rx_full && !r_rx_valid) begin
            r_state <= S_RXRD;
          end else if (w_tx_empty && i_tx_valid) begin
            r_state <= S_TXWR;
          end else if (GAP_EN) begin
            r_state   <= S_GAP;
            r_gap_cnt <= GAP_LOAD;
          end else begin
            r_state <= S_POLL;
          end
        end
        S_RXRD:     r_state <= S_RXCAP;
        S_RXCAP: begin
          r_rx_data  <= i_acia_dout;
          r_rx_valid <= 1'b1;
          r_state    <= S_POLL;
        end
        S_TXWR:     r_state <= S_POLL;
        S_GAP: begin
          if (r_gap_cnt == 8'd0) begin
            r_state <= S_POLL;
          end else begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end
        end
        default:    r_state <= S_INIT_RST;
      endcase
    end
  end

  // Bus strobes decode from the state register and are held low during reset.
  always_comb begin
    o_acia_cs  = 1'b0;
    o_acia_we  = 1'b0;
    o_acia_rs  = 1'b0;
    o_acia_din = 8'd0;
    o_tx_ready = 1'b0;
    if (!rst) begin
      case (r_state)
        S_INIT_RST: begin
          o_acia_cs  = 1'b1;
          o_acia_we  = 1'b1;
          o_acia_din = 8'h03;
        end
        S_INIT_CFG: begin
          o_acia_cs  = 1'b1;
          o_acia_we  = 1'b1;
          o_acia_din = CTRL_WORD;
        end
        S_POLL: begin
          o_acia_cs = 1'b1;
        end
        S_RXRD: begin
          o_acia_cs = 1'b1;
          o_acia_rs = 1'b1;
        end
        S_TXWR: begin
          // If the producer withdrew, the slot passes with no access.
          o_acia_cs  = i_tx_valid;
          o_acia_we  = 1'b1;
          o_acia_rs  = 1'b1;
          o_acia_din = i_tx_data;
          o_tx_ready = i_tx_valid;
        end
        default: begin
          o_acia_cs = 1'b0;
        end
      endcase
    end
  end

  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_rx_err   = r_rx_err;

endmodule

// File: tb/tb_acia_bridge.sv
// tb_acia_bridge: directed sequencing checks plus a randomised stream phase
// against a behavioural ACIA; tx/rx bytes are checked through scoreboards.
module tb_acia_bridge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       acia_cs, acia_we, acia_rs;
  logic [7:0] acia_din;
  logic [7:0] acia_dout = 8'h00;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       rx_err;
  logic       err_clr = 1'b0;

  // second instance with POLL_GAP = 3, idle ACIA (status always 0)
  logic       g_cs, g_we, g_rs, g_tx_ready, g_rx_valid, g_rx_err;
  logic [7:0] g_din, g_rx_data;
  logic [7:0] g_dout = 8'h00;
  logic [7:0] g_tx_data = 8'h00;
  logic       g_tx_valid = 1'b0;
  logic       g_rx_ready = 1'b0;
  logic       g_err_clr = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  acia_bridge dut (
    .clk(clk), .rst(rst),
    .o_acia_cs(acia_cs), .o_acia_we(acia_we), .o_acia_rs(acia_rs),
    .o_acia_din(acia_din), .i_acia_dout(acia_dout),
    .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .o_rx_data(rx_data), .o_rx_valid(rx_valid), .i_rx_ready(rx_ready),
    .o_rx_err(rx_err), .i_err_clr(err_clr)
  );

  acia_bridge #(.CTRL_WORD(8'h15), .POLL_GAP(3)) dut_g (
    .clk(clk), .rst(rst),
    .o_acia_cs(g_cs), .o_acia_we(g_we), .o_acia_rs(g_rs),
    .o_acia_din(g_din), .i_acia_dout(g_dout),
    .i_tx_data(g_tx_data), .i_tx_valid(g_tx_valid), .o_tx_ready(g_tx_ready),
    .o_rx_data(g_rx_data), .o_rx_valid(g_rx_valid), .i_rx_ready(g_rx_ready),
    .o_rx_err(g_rx_err), .i_err_clr(g_err_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s got=%0h want=none", name, act);
  endtask

  function automatic logic [10:0] bx(input logic cs, input logic we, input logic rs, input logic [7:0] d);
    return {cs, we, rs, d};
  endfunction

  function automatic logic [10:0] bus();
    return {acia_cs, acia_we, acia_rs, acia_din};
  endfunction

  function automatic bit is_poll(input bit g);
    return g ? (g_cs && !g_we && !g_rs) : (acia_cs && !acia_we && !acia_rs);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural ACIA ----------------
  logic [7:0] m_stat = 8'h00;
  logic [7:0] m_rxd = 8'h00;
  bit         auto_m = 1'b0;
  int         txe_tmr = 0;
  logic [7:0] rx_src[64];
  int         rx_idx = 0;
  int         rx_n = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  always @(posedge clk) begin
    if (acia_cs && !acia_we) acia_dout <= acia_rs ? m_rxd : m_stat;
    if (auto_m) begin
      if (acia_cs && !acia_we && acia_rs) begin
        m_stat[0] <= 1'b0;
      end else if (!m_stat[0] && rx_idx < rx_n && $urandom_range(0, 3) == 0) begin
        m_rxd     <= rx_src[rx_idx];
        m_stat[0] <= 1'b1;
        rx_q.push_back(rx_src[rx_idx]);
        rx_idx    <= rx_idx + 1;
      end
      if (acia_cs && acia_we && acia_rs) begin
        m_stat[1] <= 1'b0;
        txe_tmr   <= $urandom_range(1, 6);
      end else if (txe_tmr > 0) begin
        txe_tmr <= txe_tmr - 1;
        if (txe_tmr == 1) m_stat[1] <= 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int wr_cnt = 0;
  int rd_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (acia_cs && acia_we && acia_rs) begin
        wr_cnt <= wr_cnt + 1;
        chk("tx_ready_on_wr", tx_ready, 1);
        if (tx_q.size() == 0) fail_now("tx_unexpected_wr", acia_din);
        else chk("tx_byte", acia_din, tx_q.pop_front());
      end
      if (tx_ready && !(acia_cs && acia_we && acia_rs)) fail_now("tx_ready_no_wr", bus());
      if (acia_cs && !acia_we) begin
        chk("din_zero_on_read", acia_din, 0);
        if (acia_rs) rd_cnt <= rd_cnt + 1;
      end
      if (rx_valid && rx_ready) begin
        if (rx_q.size() == 0) fail_now("rx_unexpected", rx_data);
        else chk("rx_byte", rx_data, rx_q.pop_front());
      end
    end
  end

  task automatic wait_poll(input bit g);
    for (int k = 0; k < 20; k++) begin
      if (is_poll(g)) return;
      tick();
    end
    fail_now("wait_poll_timeout", {31'd0, g});
  endtask

  task automatic period(input bit g, output int p);
    p = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (is_poll(g)) begin
        p = k;
        return;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, w0, r0;
    bit acc;

    // reset values and init sequence
    repeat (3) tick();
    chk("rst_bus", bus(), 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_err", rx_err, 0);
    rst = 1'b0;
    #1;
    chk("init_rst_bus", bus(), bx(1, 1, 0, 8'h03));
    tick();
    chk("init_cfg_bus", bus(), bx(1, 1, 0, 8'h15));
    tick();
    chk("first_poll_bus", bus(), bx(1, 0, 0, 8'h00));
    tick();
    chk("stat_no_cs", acia_cs, 0);
    period(1'b0, p);
    chk("idle_period_gap0", p, 1);
    period(1'b0, p);
    chk("idle_period_gap0", p, 2);

    // TX: one write at n+2, none after
    wait_poll(1'b0);
    w0 = wr_cnt;
    m_stat = 8'h02; tx_data = 8'h41; tx_valid = 1'b1; tx_q.push_back(8'h41);
    tick();
    chk("tx_stat_idle", acia_cs, 0);
    tick();
    chk("tx_wr_bus", bus(), bx(1, 1, 1, 8'h41));
    chk("tx_ready_n2", tx_ready, 1);
    m_stat = 8'h00;
    tick();
    tx_valid = 1'b0;
    chk("tx_ready_drop", tx_ready, 0);
    chk("tx_next_poll", bus(), bx(1, 0, 0, 8'h00));
    repeat (6) tick();
    chk("tx_single_write", wr_cnt - w0, 1);

    // RX: read at n+2, rx_valid at n+4, back-pressure holds further reads
    wait_poll(1'b0);
    r0 = rd_cnt;
    m_stat = 8'h01; m_rxd = 8'h5A; rx_ready = 1'b0; rx_q.push_back(8'h5A);
    tick();
    tick();
    chk("rx_rd_bus", bus(), bx(1, 0, 1, 8'h00));
    tick();
    chk("rx_valid_n3", rx_valid, 0);
    tick();
    chk("rx_valid_n4", rx_valid, 1);
    chk("rx_data_n4", rx_data, 8'h5A);
    repeat (10) tick();
    chk("rx_backpressure_reads", rd_cnt - r0, 1);
    chk("rx_still_valid", rx_valid, 1);
    m_stat = 8'h00;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("rx_popped", rx_valid, 0);

    // simultaneous RX and TX: RX first, TX at n+6
    wait_poll(1'b0);
    m_stat = 8'h03; m_rxd = 8'h33; rx_q.push_back(8'h33);
    tx_data = 8'h99; tx_valid = 1'b1; tx_q.push_back(8'h99);
    tick();
    tick();
    chk("sim_rx_first", bus(), bx(1, 0, 1, 8'h00));
    chk("sim_no_tx_ready", tx_ready, 0);
    m_stat = 8'h02;
    tick();
    tick();
    chk("sim_poll_n4", bus(), bx(1, 0, 0, 8'h00));
    chk("sim_rx_data", rx_data, 8'h33);
    tick();
    tick();
    chk("sim_tx_n6", bus(), bx(1, 1, 1, 8'h99));
    chk("sim_tx_ready_n6", tx_ready, 1);
    m_stat = 8'h00;
    tick();
    tx_valid = 1'b0;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("sim_rx_popped", rx_valid, 0);

    // errors: sticky, clearable, set beats clear
    wait_poll(1'b0);
    m_stat = 8'h31; m_rxd = 8'h12; rx_q.push_back(8'h12); rx_ready = 1'b1;
    tick();
    chk("err_not_yet", rx_err, 0);
    tick();
    chk("err_set", rx_err, 1);
    chk("err_rx_read", bus(), bx(1, 0, 1, 8'h00));
    m_stat = 8'h00;
    repeat (8) tick();
    rx_ready = 1'b0;
    chk("err_sticky", rx_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared", rx_err, 0);
    wait_poll(1'b0);
    m_stat = 8'h20;
    tick();
    err_clr = 1'b1;
    m_stat = 8'h00;
    tick();
    err_clr = 1'b0;
    chk("err_set_wins", rx_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared2", rx_err, 0);

    // randomised streams against the behavioural ACIA
    for (int i = 0; i < 40; i++) rx_src[i] = 8'($urandom);
    rx_n = 40;
    rx_idx = 0;
    m_stat = 8'h02;
    w0 = wr_cnt;
    auto_m = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          tx_data = 8'($urandom);
          tx_valid = 1'b1;
          tx_q.push_back(tx_data);
          acc = 1'b0;
          for (int c = 0; c < 300 && !acc; c++) begin
            acc = tx_ready;
            tick();
          end
          tx_valid = 1'b0;
          if (!acc) begin
            fail_now("rand_tx_timeout", i);
            break;
          end
          repeat ($urandom_range(0, 3)) tick();
        end
      end
      begin
        for (int c = 0; c < 6000; c++) begin
          rx_ready = ($urandom_range(0, 2) != 0);
          tick();
          if (rx_idx == rx_n && rx_q.size() == 0) break;
        end
        rx_ready = 1'b0;
      end
    join
    repeat (4) tick();
    auto_m = 1'b0;
    chk("rand_rx_all_sent", rx_idx, 40);
    chk("rand_rx_q_empty", rx_q.size(), 0);
    chk("rand_tx_q_empty", tx_q.size(), 0);
    chk("rand_tx_writes", wr_cnt - w0, 40);

    // reset in the middle of a TX write, with an rx byte still buffered
    m_stat = 8'h00;
    repeat (4) tick();
    wait_poll(1'b0);
    m_stat = 8'h01; m_rxd = 8'hEE; rx_ready = 1'b0;
    tick();
    tick();
    m_stat = 8'h02; tx_data = 8'hC3; tx_valid = 1'b1;
    repeat (4) tick();
    chk("rst_pre_txwr", bus(), bx(1, 1, 1, 8'hC3));
    chk("rst_pre_rx_valid", rx_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_cs", acia_cs, 0);
    chk("rst_mid_tx_ready", tx_ready, 0);
    tick();
    chk("rst_rx_valid_clr", rx_valid, 0);
    chk("rst_rx_data_clr", rx_data, 0);
    chk("rst_bus_zero", bus(), 0);
    tx_valid = 1'b0;
    m_stat = 8'h00;
    rst = 1'b0;
    #1;
    chk("reinit_rst_bus", bus(), bx(1, 1, 0, 8'h03));
    tick();
    chk("reinit_cfg_bus", bus(), bx(1, 1, 0, 8'h15));
    tick();
    chk("reinit_poll", bus(), bx(1, 0, 0, 8'h00));

    // POLL_GAP = 3 instance: idle period 5
    wait_poll(1'b1);
    period(1'b1, p);
    chk("gap3_period", p, 5);
    period(1'b1, p);
    chk("gap3_period2", p, 5);
    chk("gap3_rx_valid", g_rx_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
